// File: rtl/circle_cmd_sched.sv
// circle_cmd_sched: queues circle draw commands and issues them one at a time
// to the circle engine over a level start/done handshake.
// Optional feature macro: SKIP_OFFSCREEN_EN (drops commands whose circle lies
// entirely off the 160x120 screen and counts them on skipped_count).
//
// state       | meaning
// S_IDLE      | waiting for a queued command, the idle gap and circ_done low
// S_WAIT_DONE | circ_start held high, waiting for circ_done
// S_RELEASE   | circ_start dropped, waiting for circ_done to fall

module circle_cmd_sched #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_centre_x,
    input  logic [6:0]               cmd_centre_y,
    input  logic [7:0]               cmd_radius,
    input  logic [2:0]               cmd_colour,
    output logic                     circ_start,
    input  logic                     circ_done,
    output logic [7:0]               circ_centre_x,
    output logic [6:0]               circ_centre_y,
    output logic [7:0]               circ_radius,
    output logic [2:0]               circ_colour,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   cmd_count,
`ifdef SKIP_OFFSCREEN_EN
    output logic [15:0]              skipped_count,
`endif
    output logic [15:0]              drawn_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DONE = 2'd1,
        S_RELEASE   = 2'd2
    } state_t;

    state_t          state_q;
    logic [25:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [7:0]      gap_q;

    logic            full, empty, push, pop, gap_ok;
    logic [7:0]      head_x;
    logic [6:0]      head_y;
    logic [7:0]      head_r;
    logic [2:0]      head_c;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign gap_ok    = (gap_q >= 8'(GAP_CYCLES));
    // A pop is the issue decision itself; with skipping enabled it may discard.
    assign pop       = (state_q == S_IDLE) && !empty && gap_ok && !circ_done;
    assign busy      = (state_q != S_IDLE) || !empty;
    assign cmd_count = count_q;
    assign {head_x, head_y, head_r, head_c} = mem_q[rd_ptr_q];

`ifdef SKIP_OFFSCREEN_EN
    logic offscreen;
    // 9-bit compare so 160+r and 120+r never overflow.
    assign offscreen = ({1'b0, head_x} >= (9'd160 + {1'b0, head_r})) ||
                       ({2'b0, head_y} >= (9'd120 + {1'b0, head_r}));
`endif

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_centre_x, cmd_centre_y, cmd_radius, cmd_colour};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Issue FSM with registered engine outputs, idle-gap counter and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            circ_start    <= 1'b0;
            circ_centre_x <= '0;
            circ_centre_y <= '0;
            circ_radius   <= '0;
            circ_colour   <= '0;
            drawn_count   <= '0;
            gap_q         <= 8'(GAP_CYCLES);
`ifdef SKIP_OFFSCREEN_EN
            skipped_count <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
`ifdef SKIP_OFFSCREEN_EN
                        if (offscreen) begin
                            skipped_count <= skipped_count + 16'd1;
                            gap_q         <= '0;
                        end else
`endif
                        begin
                            state_q       <= S_WAIT_DONE;
                            circ_start    <= 1'b1;
                            circ_centre_x <= head_x;
                            circ_centre_y <= head_y;
                            circ_radius   <= head_r;
                            circ_colour   <= head_c;
                        end
                    end else if (!gap_ok) begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (circ_done) begin
                        state_q     <= S_RELEASE;
                        circ_start  <= 1'b0;
                        drawn_count <= drawn_count + 16'd1;
                    end
                end
                S_RELEASE: begin
                    if (!circ_done) begin
                        state_q <= S_IDLE;
                        gap_q   <= '0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    circ_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_circle_cmd_sched.sv
// Self-checking bench for circle_cmd_sched: scoreboard of issued commands,
// one task per scenario. Define SKIP_OFFSCREEN_EN to also exercise skipping.

module tb_circle_cmd_sched;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_x;
    logic [6:0]    cmd_y;
    logic [7:0]    cmd_r;
    logic [2:0]    cmd_c;
    logic          circ_start;
    logic          circ_done;
    logic [7:0]    circ_x;
    logic [6:0]    circ_y;
    logic [7:0]    circ_r;
    logic [2:0]    circ_c;
    logic          busy;
    logic [CW-1:0] cmd_count;
    logic [15:0]   drawn_count;
`ifdef SKIP_OFFSCREEN_EN
    logic [15:0]   skipped_count;
`endif

    logic [25:0]   circ_vec;
    assign circ_vec = {circ_x, circ_y, circ_r, circ_c};

    int            checks = 0;
    int            passes = 0;
    logic [25:0]   exp_q[$];
    logic [25:0]   exp;
    logic [25:0]   last_exp = '0;
    logic [15:0]   exp_drawn = '0;

    circle_cmd_sched #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_centre_x  (cmd_x),
        .cmd_centre_y  (cmd_y),
        .cmd_radius    (cmd_r),
        .cmd_colour    (cmd_c),
        .circ_start    (circ_start),
        .circ_done     (circ_done),
        .circ_centre_x (circ_x),
        .circ_centre_y (circ_y),
        .circ_radius   (circ_r),
        .circ_colour   (circ_c),
        .busy          (busy),
        .cmd_count     (cmd_count),
`ifdef SKIP_OFFSCREEN_EN
        .skipped_count (skipped_count),
`endif
        .drawn_count   (drawn_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle push attempt; expected issue order recorded on the scoreboard.
    task automatic drive_cmd(input logic [25:0] c, input bit will_issue);
        cmd_valid = 1'b1;
        {cmd_x, cmd_y, cmd_r, cmd_c} = c;
        if (will_issue) exp_q.push_back(c);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        int n = 0;
        while (!circ_start && n < 40) begin
            tick();
            n++;
        end
        ok = circ_start;
    endtask

    task automatic pulse_done();
        circ_done = 1'b1;
        tick();
        circ_done = 1'b0;
        tick();
        exp_drawn = exp_drawn + 16'd1;
    endtask

    function automatic logic [25:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        checks++;
        if (circ_start !== 1'b0 || circ_vec !== 26'd0) begin
            $display("FAIL reset_circ: start=%b vec=%h required start=0 vec=0", circ_start, circ_vec);
        end else passes++;
        checks++;
        if (busy !== 1'b0 || cmd_count !== '0 || drawn_count !== 16'd0) begin
            $display("FAIL reset_status: busy=%b count=%0d drawn=%0d required 0/0/0", busy, cmd_count, drawn_count);
        end else passes++;
        checks++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL reset_ready: cmd_ready=%b required 1 (FIFO empty)", cmd_ready);
        end else passes++;
    endtask

    task automatic test_single();
        logic [25:0] c = {8'd80, 7'd60, 8'd20, 3'd5};
        drive_cmd(c, 1'b1);
        checks++;
        if (circ_start !== 1'b0 || cmd_count !== CW'(1)) begin
            $display("FAIL single_latency1: start=%b count=%0d required start=0 count=1", circ_start, cmd_count);
        end else passes++;
        tick();
        exp = pop_exp();
        checks++;
        if (circ_start !== 1'b1 || circ_vec !== exp || cmd_count !== '0 || busy !== 1'b1) begin
            $display("FAIL single_issue: start=%b vec=%h count=%0d busy=%b required 1/%h/0/1",
                     circ_start, circ_vec, cmd_count, busy, exp);
        end else passes++;
        last_exp = exp;
        circ_done = 1'b1;
        tick();
        checks++;
        if (circ_start !== 1'b0 || drawn_count !== 16'd1) begin
            $display("FAIL single_done: start=%b drawn=%0d required start=0 drawn=1", circ_start, drawn_count);
        end else passes++;
        circ_done = 1'b0;
        tick();
        exp_drawn = 16'd1;
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL single_idle: busy=%b required 0", busy);
        end else passes++;
    endtask

    task automatic test_back_to_back();
        logic [25:0] c6 = {8'd66, 7'd66, 8'd6, 3'd6};
        bit ok;
        int n;
        repeat (GAP + 1) tick();
        for (int i = 0; i <= DEPTH; i++) begin
            logic [25:0] c = {8'(10 + i), 7'(20 + i), 8'(i + 1), 3'(i)};
            checks++;
            if (cmd_ready !== 1'b1) begin
                $display("FAIL b2b_ready_%0d: cmd_ready=%b required 1", i, cmd_ready);
            end else passes++;
            cmd_valid = 1'b1;
            {cmd_x, cmd_y, cmd_r, cmd_c} = c;
            exp_q.push_back(c);
            tick();
        end
        {cmd_x, cmd_y, cmd_r, cmd_c} = c6;
        checks++;
        if (cmd_ready !== 1'b0 || cmd_count !== CW'(DEPTH) || circ_start !== 1'b1) begin
            $display("FAIL b2b_full: ready=%b count=%0d start=%b required 0/%0d/1",
                     cmd_ready, cmd_count, circ_start, DEPTH);
        end else passes++;
        exp = pop_exp();
        checks++;
        if (circ_vec !== exp) begin
            $display("FAIL b2b_first: vec=%h required %h", circ_vec, exp);
        end else passes++;
        last_exp = exp;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (cmd_count !== CW'(DEPTH) || circ_vec !== last_exp) begin
                $display("FAIL b2b_hold_%0d: count=%0d vec=%h required %0d/%h",
                         k, cmd_count, circ_vec, DEPTH, last_exp);
            end else passes++;
        end
        circ_done = 1'b1;
        tick();
        circ_done = 1'b0;
        exp_drawn = exp_drawn + 16'd1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL b2b_unblock: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
        end else passes++;
        exp_q.push_back(c6);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            wait_start(ok);
            exp = pop_exp();
            checks++;
            if (!ok || circ_vec !== exp) begin
                $display("FAIL b2b_order_%0d: start=%b vec=%h required 1/%h", n, ok, circ_vec, exp);
            end else passes++;
            last_exp = exp;
            pulse_done();
            n++;
        end
        checks++;
        if (cmd_count !== '0 || busy !== 1'b0 || drawn_count !== exp_drawn) begin
            $display("FAIL b2b_drained: count=%0d busy=%b drawn=%0d required 0/0/%0d",
                     cmd_count, busy, drawn_count, exp_drawn);
        end else passes++;
    endtask

    task automatic test_done_hold();
        logic [25:0] a = {8'd30, 7'd31, 8'd3, 3'd1};
        logic [25:0] b = {8'd40, 7'd41, 8'd4, 3'd2};
        logic [25:0] s = {8'd50, 7'd51, 8'd5, 3'd3};
        bit ok;
        repeat (GAP + 1) tick();
        drive_cmd(a, 1'b1);
        drive_cmd(b, 1'b1);
        wait_start(ok);
        exp = pop_exp();
        checks++;
        if (!ok || circ_vec !== exp) begin
            $display("FAIL hold_first: start=%b vec=%h required 1/%h", ok, circ_vec, exp);
        end else passes++;
        last_exp = exp;
        circ_done = 1'b1;
        tick();
        exp_drawn = exp_drawn + 16'd1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (circ_start !== 1'b0 || circ_vec !== last_exp) begin
                $display("FAIL hold_blocked_%0d: start=%b vec=%h required 0/%h", k, circ_start, circ_vec, last_exp);
            end else passes++;
        end
        circ_done = 1'b0;
        tick();
        checks++;
        if (circ_start !== 1'b0) begin
            $display("FAIL hold_gap0: start=%b required 0", circ_start);
        end else passes++;
        for (int k = 1; k <= GAP + 1; k++) begin
            tick();
            checks++;
            if (circ_start !== (k == GAP + 1)) begin
                $display("FAIL hold_gap%0d: start=%b required %b", k, circ_start, (k == GAP + 1));
            end else passes++;
        end
        exp = pop_exp();
        checks++;
        if (circ_vec !== exp) begin
            $display("FAIL hold_second: vec=%h required %h", circ_vec, exp);
        end else passes++;
        last_exp = exp;
        pulse_done();
        // Stale done while idle must block issue until it falls.
        repeat (GAP + 1) tick();
        circ_done = 1'b1;
        drive_cmd(s, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (circ_start !== 1'b0) begin
                $display("FAIL stale_done_%0d: start=%b required 0", k, circ_start);
            end else passes++;
        end
        circ_done = 1'b0;
        tick();
        exp = pop_exp();
        checks++;
        if (circ_start !== 1'b1 || circ_vec !== exp) begin
            $display("FAIL stale_release: start=%b vec=%h required 1/%h", circ_start, circ_vec, exp);
        end else passes++;
        last_exp = exp;
        pulse_done();
    endtask

    task automatic test_reset_mid();
        repeat (GAP + 1) tick();
        for (int i = 0; i < 4; i++) drive_cmd({8'(100 + i), 7'(50 + i), 8'd9, 3'(i)}, 1'b1);
        checks++;
        if (circ_start !== 1'b1 || cmd_count !== CW'(3)) begin
            $display("FAIL rstmid_pre: start=%b count=%0d required 1/3", circ_start, cmd_count);
        end else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (circ_start !== 1'b0 || cmd_count !== '0 || busy !== 1'b0 ||
            circ_vec !== 26'd0 || drawn_count !== 16'd0) begin
            $display("FAIL rstmid: start=%b count=%0d busy=%b vec=%h drawn=%0d required all 0",
                     circ_start, cmd_count, busy, circ_vec, drawn_count);
        end else passes++;
        exp_q.delete();
        exp_drawn = '0;
        last_exp  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

`ifdef SKIP_OFFSCREEN_EN
    task automatic test_skip();
        bit ok;
        drive_cmd({8'd200, 7'd10, 8'd30, 3'd4}, 1'b0);
        tick();
        checks++;
        if (circ_start !== 1'b0 || skipped_count !== 16'd1 || cmd_count !== '0 || circ_vec !== last_exp) begin
            $display("FAIL skip_first: start=%b skipped=%0d count=%0d vec=%h required 0/1/0/%h",
                     circ_start, skipped_count, cmd_count, circ_vec, last_exp);
        end else passes++;
        drive_cmd({8'd10, 7'd10, 8'd5, 3'd2}, 1'b1);
        wait_start(ok);
        exp = pop_exp();
        checks++;
        if (!ok || circ_vec !== exp || skipped_count !== 16'd1) begin
            $display("FAIL skip_second: start=%b vec=%h skipped=%0d required 1/%h/1",
                     ok, circ_vec, skipped_count, exp);
        end else passes++;
        last_exp = exp;
        pulse_done();
        checks++;
        if (drawn_count !== exp_drawn) begin
            $display("FAIL skip_drawn: drawn=%0d required %0d", drawn_count, exp_drawn);
        end else passes++;
    endtask
`endif

    task automatic test_drawn_count();
        bit ok;
        for (int i = 0; i < 50; i++) begin
            logic [25:0] c = {8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)),
                              8'($urandom_range(0, 255)), 3'($urandom_range(0, 7))};
            drive_cmd(c, 1'b1);
            wait_start(ok);
            exp = pop_exp();
            checks++;
            if (!ok || circ_vec !== exp) begin
                $display("FAIL rand_issue_%0d: start=%b vec=%h required 1/%h", i, ok, circ_vec, exp);
            end else passes++;
            last_exp = exp;
            pulse_done();
        end
        checks++;
        if (drawn_count !== exp_drawn || busy !== 1'b0) begin
            $display("FAIL drawn_count: drawn=%0d busy=%b required %0d/0", drawn_count, busy, exp_drawn);
        end else passes++;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        circ_done = 1'b0;
        {cmd_x, cmd_y, cmd_r, cmd_c} = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_single();
        test_back_to_back();
        test_done_hold();
        test_reset_mid();
`ifdef SKIP_OFFSCREEN_EN
        test_skip();
`endif
        test_drawn_count();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
